// File: rtl/j_ffs32.sv
// ---------------------------------------------------------------------------
// j_ffs32 -- iterative 32-bit find-first-set / leading-one encoder.
//
// Scans the latched operand one 4-bit group per clock (a[3:0] .. a[31:28]),
// the same eight groups the 32-input zero detector works on, and reports the
// bit index of the first set bit in scan order, or flags an all-zero operand.
//
// Parameters:
//   MSB_FIRST  0: scan group 0 upward, report lowest set bit (find-first-set)
//              1: scan group 7 downward, report highest set bit (leading one)
//
// Ports:
//   sys_clk  in   system clock, all state on rising edge
//   resetl   in   asynchronous active-low reset
//   start    in   request; d is sampled when accepted (IDLE or DONE)
//   d        in   32-bit operand
//   busy     out  scan in progress
//   done     out  one-cycle result-valid pulse
//   zero     out  operand was all zeros (held until the next result)
//   idx      out  bit index of the found bit (held until the next result)
//
// Optional feature (macro J_FFS32_EARLY_ZERO_EN):
//   When defined, a full 32-input zero detect on d is evaluated at the
//   accepting edge; a zero operand goes straight to DONE (latency 1) without
//   ever raising busy. When undefined, a zero operand takes all 8 scan cycles.
// ---------------------------------------------------------------------------
module j_ffs32 #(
  parameter int unsigned MSB_FIRST = 0
) (
  input  logic        sys_clk,
  input  logic        resetl,
  input  logic        start,
  input  logic [31:0] d,
  output logic        busy,
  output logic        done,
  output logic        zero,
  output logic [4:0]  idx
);

  localparam bit LpMsbFirst = (MSB_FIRST != 0);

  // First and last group in scan order.
  localparam logic [2:0] LpGrpFirst = LpMsbFirst ? 3'd7 : 3'd0;
  localparam logic [2:0] LpGrpLast  = LpMsbFirst ? 3'd0 : 3'd7;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StScan = 2'd1,
    StDone = 2'd2
  } state_e;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_e      r_state;
  logic [31:0] r_data;
  logic [2:0]  r_grp;
  logic [4:0]  r_idx;
  logic        r_zero;

  state_e      w_state_d;
  logic [31:0] w_data_d;
  logic [2:0]  w_grp_d;
  logic [4:0]  w_idx_d;
  logic        w_zero_d;

  // -------------------------------------------------------------------------
  // Group select and in-group position
  // -------------------------------------------------------------------------
  logic [3:0] w_nib;
  logic       w_nib_nz;
  logic       w_grp_last;
  logic [1:0] w_pos;
  logic       w_start_ok;
  logic       w_d_zero;

  // Lowest set bit of a nibble; caller guarantees the nibble is nonzero.
  function automatic logic [1:0] f_pos_lo(input logic [3:0] n);
    logic [1:0] p;
    if (n[0])      p = 2'd0;
    else if (n[1]) p = 2'd1;
    else if (n[2]) p = 2'd2;
    else           p = 2'd3;
    return p;
  endfunction

  // Highest set bit of a nibble; caller guarantees the nibble is nonzero.
  function automatic logic [1:0] f_pos_hi(input logic [3:0] n);
    logic [1:0] p;
    if (n[3])      p = 2'd3;
    else if (n[2]) p = 2'd2;
    else if (n[1]) p = 2'd1;
    else           p = 2'd0;
    return p;
  endfunction

  assign w_nib      = r_data[{r_grp, 2'b00} +: 4];
  assign w_nib_nz   = |w_nib;
  assign w_grp_last = (r_grp == LpGrpLast);
  assign w_pos      = LpMsbFirst ? f_pos_hi(w_nib) : f_pos_lo(w_nib);

  // A new request is only taken when no scan is in flight.
  assign w_start_ok = start && (r_state != StScan);

`ifdef J_FFS32_EARLY_ZERO_EN
  assign w_d_zero = ~|d;
`else
  assign w_d_zero = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_d = r_state;
    w_data_d  = r_data;
    w_grp_d   = r_grp;
    w_idx_d   = r_idx;
    w_zero_d  = r_zero;

    unique case (r_state)
      StIdle, StDone: begin
        if (w_start_ok) begin
          w_data_d = d;
          w_grp_d  = LpGrpFirst;
          if (w_d_zero) begin
            // Early-zero shortcut: result is known at the accepting edge.
            w_state_d = StDone;
            w_zero_d  = 1'b1;
            w_idx_d   = 5'd0;
          end else begin
            w_state_d = StScan;
          end
        end else if (r_state == StDone) begin
          w_state_d = StIdle;
        end
      end

      StScan: begin
        if (w_nib_nz) begin
          w_idx_d   = {r_grp, w_pos};
          w_zero_d  = 1'b0;
          w_state_d = StDone;
        end else if (w_grp_last) begin
          w_idx_d   = 5'd0;
          w_zero_d  = 1'b1;
          w_state_d = StDone;
        end else begin
          w_grp_d = LpMsbFirst ? (r_grp - 3'd1) : (r_grp + 3'd1);
        end
      end

      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) begin
      r_state <= StIdle;
      r_data  <= 32'd0;
      r_grp   <= 3'd0;
      r_idx   <= 5'd0;
      r_zero  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_data  <= w_data_d;
      r_grp   <= w_grp_d;
      r_idx   <= w_idx_d;
      r_zero  <= w_zero_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs: busy and done decode straight from the state, so they can never
  // be high together and both drop the moment reset asserts.
  // -------------------------------------------------------------------------
  assign busy = (r_state == StScan);
  assign done = (r_state == StDone);
  assign zero = r_zero;
  assign idx  = r_idx;

endmodule
